// File: rtl/gfx_pkg.sv
// Shared raster-pipeline definitions: screen geometry defaults,
// framebuffer widths and the span writer state encoding.
package gfx_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int ADDR_W   = 19;
   localparam int COLOR_W  = 16;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      WRITE,
      DONE
   } span_state_t;

endpackage

// File: rtl/span_clip.sv
// Span clipper: flags spans that miss the screen, clamps the rest.
// Ports: i_xl/i_xr ordered endpoints, i_y scanline (signed);
//        o_xs/o_xe clipped endpoints, o_empty span has no pixels.
module span_clip
   import gfx_pkg::*;
#(
   parameter int SCREEN_W = gfx_pkg::SCREEN_W,
   parameter int SCREEN_H = gfx_pkg::SCREEN_H
) (
   input  logic signed [15:0] i_xl,
   input  logic signed [15:0] i_xr,
   input  logic signed [15:0] i_y,
   output logic signed [15:0] o_xs,
   output logic signed [15:0] o_xe,
   output logic               o_empty
);

   localparam logic signed [15:0] L_W    = 16'(SCREEN_W);
   localparam logic signed [15:0] L_H    = 16'(SCREEN_H);
   localparam logic signed [15:0] L_XMAX = 16'(SCREEN_W - 1);

   always_comb begin
      o_empty = (i_y < 16'sd0) || (i_y >= L_H) ||
                (i_xr < 16'sd0) || (i_xl >= L_W);
      o_xs    = (i_xl < 16'sd0) ? 16'sd0 : i_xl;
      o_xe    = (i_xr > L_XMAX) ? L_XMAX : i_xr;
   end

endmodule

// File: rtl/span_fill_writer.sv
// Span fill writer: takes one horizontal span per handshake and emits
// one framebuffer write per visible pixel, then pulses span_done.
// Ports: clk, reset (sync, active-high); span_valid/span_ready with
//        span_y/x0/x1/color; fb_we/fb_addr/fb_data with fb_ready;
//        span_done one-cycle completion pulse; busy when not idle.
module span_fill_writer
   import gfx_pkg::*;
#(
   parameter int SCREEN_W = gfx_pkg::SCREEN_W,
   parameter int SCREEN_H = gfx_pkg::SCREEN_H,
   parameter int ADDR_W   = gfx_pkg::ADDR_W,
   parameter int COLOR_W  = gfx_pkg::COLOR_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                span_valid,
   output logic                span_ready,
   input  logic signed [15:0]  span_y,
   input  logic signed [15:0]  span_x0,
   input  logic signed [15:0]  span_x1,
   input  logic [COLOR_W-1:0]  span_color,
   output logic                fb_we,
   output logic [ADDR_W-1:0]   fb_addr,
   output logic [COLOR_W-1:0]  fb_data,
   input  logic                fb_ready,
   output logic                span_done,
   output logic                busy
);

   localparam logic [ADDR_W-1:0] L_LINE = ADDR_W'(SCREEN_W);

   span_state_t r_state;
   span_state_t w_next;

   logic signed [15:0] r_y;
   logic signed [15:0] r_xl;
   logic signed [15:0] r_xr;
   logic signed [15:0] r_x;
   logic signed [15:0] r_xe;
   logic [COLOR_W-1:0] r_color;
   logic [ADDR_W-1:0]  r_addr;

   logic signed [15:0] w_xs;
   logic signed [15:0] w_xe;
   logic               w_empty;
   logic               w_last;
   logic [ADDR_W-1:0]  w_start;

   span_clip #(
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H)
   ) u_clip (
      .i_xl    (r_xl),
      .i_xr    (r_xr),
      .i_y     (r_y),
      .o_xs    (w_xs),
      .o_xe    (w_xe),
      .o_empty (w_empty)
   );

   // Only used for non-empty spans, so y and xs are non-negative here.
   assign w_start = ADDR_W'($unsigned(r_y)) * L_LINE
                  + ADDR_W'($unsigned(w_xs));
   assign w_last  = (r_x == r_xe);

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      span_ready = 1'b0;
      busy       = 1'b1;
      fb_we      = 1'b0;
      span_done  = 1'b0;
      unique case (r_state)
         IDLE: begin
            span_ready = 1'b1;
            busy       = 1'b0;
            if (span_valid) w_next = SETUP;
         end
         SETUP: w_next = w_empty ? DONE : WRITE;
         WRITE: begin
            fb_we = 1'b1;
            if (fb_ready && w_last) w_next = DONE;
         end
         DONE: begin
            span_done = 1'b1;
            w_next    = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Address and data are registers, so a stalled write stays put.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_y     <= '0;
         r_xl    <= '0;
         r_xr    <= '0;
         r_x     <= '0;
         r_xe    <= '0;
         r_color <= '0;
         r_addr  <= '0;
      end else begin
         if (r_state == IDLE && span_valid) begin
            r_y     <= span_y;
            r_color <= span_color;
            r_xl    <= (span_x0 < span_x1) ? span_x0 : span_x1;
            r_xr    <= (span_x0 < span_x1) ? span_x1 : span_x0;
         end
         if (r_state == SETUP && !w_empty) begin
            r_addr <= w_start;
            r_x    <= w_xs;
            r_xe   <= w_xe;
         end
         if (r_state == WRITE && fb_ready && !w_last) begin
            r_addr <= r_addr + 1'b1;
            r_x    <= r_x + 16'sd1;
         end
      end
   end

   assign fb_addr = r_addr;
   assign fb_data = r_color;

endmodule

// File: tb/tb_span_fill_writer.sv
// Testbench for span_fill_writer: directed and random spans against
// a pixel-list reference model, with random and alternating stalls.
module tb_span_fill_writer;
   import gfx_pkg::*;

   logic               clk = 1'b0;
   logic               reset;
   logic               span_valid;
   logic               span_ready;
   logic signed [15:0] span_y;
   logic signed [15:0] span_x0;
   logic signed [15:0] span_x1;
   logic [15:0]        span_color;
   logic               fb_we;
   logic [18:0]        fb_addr;
   logic [15:0]        fb_data;
   logic               fb_ready;
   logic               span_done;
   logic               busy;

   int n_cmp = 0;
   int n_err = 0;

   span_fill_writer dut (
      .clk        (clk),
      .reset      (reset),
      .span_valid (span_valid),
      .span_ready (span_ready),
      .span_y     (span_y),
      .span_x0    (span_x0),
      .span_x1    (span_x1),
      .span_color (span_color),
      .fb_we      (fb_we),
      .fb_addr    (fb_addr),
      .fb_data    (fb_data),
      .fb_ready   (fb_ready),
      .span_done  (span_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // stall_pct < 0 selects strictly alternating fb_ready.
   task automatic run_span(input int y, input int x0, input int x1,
                           input logic [15:0] col, input int stall_pct);
      int          q_exp[$];
      int          q_got[$];
      int          xl, xr, lo, hi, n, done_cyc;
      logic [18:0] prev_addr;
      bit          prev_stall;
      bit          rdy;
      xl = (x0 < x1) ? x0 : x1;
      xr = (x0 < x1) ? x1 : x0;
      if (!(y < 0 || y >= 480 || xr < 0 || xl >= 640)) begin
         lo = (xl < 0) ? 0 : xl;
         hi = (xr > 639) ? 639 : xr;
         for (int x = lo; x <= hi; x++) q_exp.push_back(y * 640 + x);
      end
      n = q_exp.size();
      @(negedge clk);
      check("ready_idle", span_ready, 1);
      span_valid = 1'b1;
      span_y     = 16'(y);
      span_x0    = 16'(x0);
      span_x1    = 16'(x1);
      span_color = col;
      fb_ready   = 1'b1;
      done_cyc   = -1;
      prev_stall = 1'b0;
      prev_addr  = '0;
      for (int c = 1; c < 4000 && done_cyc < 0; c++) begin
         @(negedge clk);
         span_valid = 1'b0;
         span_y     = 16'($urandom);
         span_x0    = 16'($urandom);
         span_x1    = 16'($urandom);
         span_color = 16'($urandom);
         if (prev_stall) begin
            check("stall_we", fb_we, 1);
            check("stall_addr", fb_addr, prev_addr);
            check("stall_data", fb_data, col);
         end
         if (stall_pct < 0) rdy = (c % 2 == 0);
         else rdy = ($urandom_range(0, 99) >= stall_pct);
         fb_ready = rdy;
         if (fb_we && rdy) begin
            q_got.push_back(int'(fb_addr));
            check("data", fb_data, col);
         end
         prev_stall = fb_we && !rdy;
         prev_addr  = fb_addr;
         if (span_done) begin
            done_cyc = c;
            check("busy_done", busy, 1);
         end
      end
      if (done_cyc < 0) check("timeout", 0, 1);
      check("n_writes", q_got.size(), n);
      for (int i = 0; i < n && i < q_got.size(); i++)
         check("addr", q_got[i], q_exp[i]);
      if (stall_pct == 0) check("done_cyc", done_cyc, 2 + n);
      @(negedge clk);
      check("done_pulse", span_done, 0);
      check("ready_back", span_ready, 1);
      check("busy_idle", busy, 0);
      check("we_idle", fb_we, 0);
      fb_ready = 1'b1;
   endtask

   initial begin
      reset      = 1'b1;
      span_valid = 1'b0;
      span_y     = '0;
      span_x0    = '0;
      span_x1    = '0;
      span_color = '0;
      fb_ready   = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_ready", span_ready, 1);
      check("rst_we", fb_we, 0);
      check("rst_addr", fb_addr, 0);
      check("rst_data", fb_data, 0);
      check("rst_done", span_done, 0);
      check("rst_busy", busy, 0);

      run_span(2, 10, 13, 16'hF800, 0);
      run_span(0, 20, 17, 16'h07E0, 0);
      run_span(479, 5, 5, 16'h001F, 0);
      run_span(1, -3, 2, 16'h1234, 0);
      run_span(0, 630, 700, 16'h5A5A, 0);
      run_span(5, -10, -1, 16'hAAAA, 0);
      run_span(480, 3, 9, 16'h0F0F, 0);
      run_span(-1, 3, 9, 16'hF0F0, 0);
      run_span(0, 0, 3, 16'hBEEF, -1);
      run_span(3, 639, 639, 16'h4321, 50);

      // Abort in WRITE after two of five pixels are accepted.
      @(negedge clk);
      span_valid = 1'b1;
      span_y     = 16'sd0;
      span_x0    = 16'sd0;
      span_x1    = 16'sd4;
      span_color = 16'hCAFE;
      fb_ready   = 1'b1;
      @(negedge clk);
      span_valid = 1'b0;
      @(negedge clk);
      check("rst_w0", fb_addr, 0);
      @(negedge clk);
      check("rst_w1", fb_addr, 1);
      @(negedge clk);
      check("rst_w2_we", fb_we, 1);
      reset = 1'b1;
      @(negedge clk);
      check("abort_we", fb_we, 0);
      check("abort_done", span_done, 0);
      check("abort_ready", span_ready, 1);
      check("abort_busy", busy, 0);
      reset = 1'b0;
      @(negedge clk);
      check("abort_nodone", span_done, 0);
      run_span(0, 0, 0, 16'h7777, 0);

      for (int k = 0; k < 40; k++) begin
         int y, x0, x1;
         y  = int'($urandom_range(0, 520)) - 20;
         x0 = int'($urandom_range(0, 760)) - 60;
         x1 = x0 + int'($urandom_range(0, 80)) - 40;
         run_span(y, x0, x1, 16'($urandom),
                  (k % 3 == 0) ? 0 : int'($urandom_range(0, 70)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
